// File: rtl/riscv_boot_ctrl.sv
// Boot/run controller for a picorv32 leaf: unpacks LOAD payloads into byte writes,
// gates the core reset under START/HALT, and returns one status word per command.
module riscv_boot_ctrl #(
  parameter int unsigned MEM_SIZE = 131072
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ap_start,
  input  logic [31:0] din,
  input  logic        val_in,
  output logic        ready_upward,
  output logic [31:0] dout,
  output logic        val_out,
  input  logic        ready_downward,
  output logic [23:0] instr_config_addr,
  output logic [7:0]  instr_config_din,
  output logic        instr_config_wr_en,
  output logic        core_resetn,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_BASE = 3'd1,
    ST_LOAD_WAIT = 3'd2,
    ST_LOAD_WR   = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_STATUS    = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic        run_r, run_s;
  logic [23:0] n_r, n_s;
  logic [24:0] rem_r, rem_s;          // bytes left to write, or words left to drain
  logic [1:0]  word_left_r, word_left_s;
  logic [23:0] shift_r, shift_s;
  logic [23:0] next_addr_r, next_addr_s;
  logic [23:0] checksum_r, checksum_s;
  logic        ready_r, ready_s;
  logic [31:0] dout_r, dout_s;
  logic        val_out_r, val_out_s;
  logic [23:0] addr_r, addr_s;
  logic [7:0]  bdin_r, bdin_s;
  logic        wr_en_r, wr_en_s;
  logic        core_resetn_r, core_resetn_s;
  logic        busy_r, busy_s;
  logic        accept_s;
  logic [24:0] end_s;

  // Next-state and next-output computation for every registered signal.
  always_comb begin
    state_s       = state_r;
    run_s         = run_r;
    n_s           = n_r;
    rem_s         = rem_r;
    word_left_s   = word_left_r;
    shift_s       = shift_r;
    next_addr_s   = next_addr_r;
    checksum_s    = checksum_r;
    dout_s        = dout_r;
    addr_s        = addr_r;
    bdin_s        = bdin_r;
    wr_en_s       = 1'b0;
    accept_s      = val_in & ready_r;
    end_s         = {1'b0, din[23:0]} + {1'b0, n_r};

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (din[31:24])
            8'h01: begin
              run_s      = 1'b0;
              n_s        = din[23:0];
              checksum_s = 24'h0;
              state_s    = ST_LOAD_BASE;
            end
            8'h02: begin
              run_s   = 1'b1;
              dout_s  = {8'h02, 24'h0};
              state_s = ST_STATUS;
            end
            8'h03: begin
              run_s   = 1'b0;
              dout_s  = {8'h03, 24'h0};
              state_s = ST_STATUS;
            end
            default: begin
              dout_s  = {8'hEE, 8'h02, 8'h00, din[31:24]};
              state_s = ST_STATUS;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_BASE: begin
        if (accept_s) begin
          next_addr_s = din[23:0];
          if (end_s > 25'(MEM_SIZE)) begin
            dout_s = {8'hEE, 8'h01, 8'h00, 8'h01};
            rem_s  = ({1'b0, n_r} + 25'd3) >> 2;
            if (n_r == 24'h0) begin
              state_s = ST_STATUS;
            end else begin
              state_s = ST_DRAIN;
            end
          end else if (n_r == 24'h0) begin
            dout_s  = {8'h01, checksum_r};
            state_s = ST_STATUS;
          end else begin
            rem_s   = {1'b0, n_r};
            state_s = ST_LOAD_WAIT;
          end
        end else begin
          state_s = ST_LOAD_BASE;
        end
      end
      ST_LOAD_WAIT: begin
        // The first byte leaves on the accept edge so four bytes fit in t+1..t+4.
        if (accept_s) begin
          wr_en_s     = 1'b1;
          bdin_s      = din[7:0];
          addr_s      = next_addr_r;
          next_addr_s = next_addr_r + 24'd1;
          checksum_s  = checksum_r + {16'h0, din[7:0]};
          shift_s     = din[31:8];
          rem_s       = rem_r - 25'd1;
          word_left_s = (rem_r >= 25'd4) ? 2'd3 : 2'(rem_r - 25'd1);
          state_s     = ST_LOAD_WR;
        end else begin
          state_s = ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WR: begin
        if (word_left_r != 2'd0) begin
          wr_en_s     = 1'b1;
          bdin_s      = shift_r[7:0];
          addr_s      = next_addr_r;
          next_addr_s = next_addr_r + 24'd1;
          checksum_s  = checksum_r + {16'h0, shift_r[7:0]};
          shift_s     = {8'h00, shift_r[23:8]};
          rem_s       = rem_r - 25'd1;
          word_left_s = word_left_r - 2'd1;
        end else if (rem_r == 25'd0) begin
          dout_s  = {8'h01, checksum_r};
          state_s = ST_STATUS;
        end else begin
          state_s = ST_LOAD_WAIT;
        end
      end
      ST_DRAIN: begin
        if (accept_s) begin
          rem_s = rem_r - 25'd1;
          if (rem_r == 25'd1) begin
            state_s = ST_STATUS;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_STATUS: begin
        if (ready_downward) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STATUS;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    case (state_s)
      ST_IDLE, ST_LOAD_BASE, ST_LOAD_WAIT, ST_DRAIN: ready_s = 1'b1;
      default:                                       ready_s = 1'b0;
    endcase
    val_out_s     = (state_s == ST_STATUS);
    busy_s        = (state_s != ST_IDLE);
    core_resetn_s = run_s & ap_start;
  end

  // State and registered outputs; reset abandons any load in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      run_r         <= 1'b0;
      n_r           <= 24'h0;
      rem_r         <= 25'h0;
      word_left_r   <= 2'd0;
      shift_r       <= 24'h0;
      next_addr_r   <= 24'h0;
      checksum_r    <= 24'h0;
      ready_r       <= 1'b0;
      dout_r        <= 32'h0;
      val_out_r     <= 1'b0;
      addr_r        <= 24'h0;
      bdin_r        <= 8'h0;
      wr_en_r       <= 1'b0;
      core_resetn_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      run_r         <= run_s;
      n_r           <= n_s;
      rem_r         <= rem_s;
      word_left_r   <= word_left_s;
      shift_r       <= shift_s;
      next_addr_r   <= next_addr_s;
      checksum_r    <= checksum_s;
      ready_r       <= ready_s;
      dout_r        <= dout_s;
      val_out_r     <= val_out_s;
      addr_r        <= addr_s;
      bdin_r        <= bdin_s;
      wr_en_r       <= wr_en_s;
      core_resetn_r <= core_resetn_s;
      busy_r        <= busy_s;
    end
  end

  assign ready_upward       = ready_r;
  assign dout               = dout_r;
  assign val_out            = val_out_r;
  assign instr_config_addr  = addr_r;
  assign instr_config_din   = bdin_r;
  assign instr_config_wr_en = wr_en_r;
  assign core_resetn        = core_resetn_r;
  assign busy               = busy_r;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Self-checking bench for riscv_boot_ctrl: directed scenarios plus randomized
// command streams checked against a byte-level reference model.
module tb_riscv_boot_ctrl;

  localparam int MEM = 131072;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ap_start;
  logic [31:0] din;
  logic        val_in;
  logic        ready_upward;
  logic [31:0] dout;
  logic        val_out;
  logic        ready_downward;
  logic [23:0] instr_config_addr;
  logic [7:0]  instr_config_din;
  logic        instr_config_wr_en;
  logic        core_resetn;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] wq[$];          // observed writes {addr, data}
  logic [31:0] load_data[$];
  bit          run_m;

  riscv_boot_ctrl #(.MEM_SIZE(MEM)) dut (
    .clk(clk), .resetn(resetn), .ap_start(ap_start), .din(din), .val_in(val_in),
    .ready_upward(ready_upward), .dout(dout), .val_out(val_out),
    .ready_downward(ready_downward), .instr_config_addr(instr_config_addr),
    .instr_config_din(instr_config_din), .instr_config_wr_en(instr_config_wr_en),
    .core_resetn(core_resetn), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (instr_config_wr_en === 1'b1) wq.push_back({instr_config_addr, instr_config_din});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    din = w;
    val_in = 1'b1;
    while (ready_upward !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", {31'h0, ready_upward}, 32'd1);
    @(posedge clk);
    #1 val_in = 1'b0;
  endtask

  task automatic get_status(input string tag, input logic [31:0] exp);
    int n = 0;
    while (val_out !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'h0, val_out}, 32'd1);
    chk(tag, dout, exp);
    chk({tag, "_rdy"}, {31'h0, ready_upward}, 32'd0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    ready_downward = 1'b1;
    @(posedge clk);
    #1 ready_downward = 1'b0;
  endtask

  // Full LOAD transaction; expected writes come from the byte-stream definition.
  task automatic run_load(input int n, input int b);
    int words;
    bit err;
    logic [23:0] sum;
    logic [31:0] exp_q[$];
    logic [7:0] bv;
    words = (n + 3) / 4;
    err = (b + n > MEM);
    sum = 24'h0;
    exp_q.delete();
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        bv = 8'(load_data[i / 4] >> (8 * (i % 4)));
        exp_q.push_back({24'(b + i), bv});
        sum = sum + {16'h0, bv};
      end
    end
    wq.delete();
    send({8'h01, 24'(n)});
    run_m = 1'b0;
    chk("load_core_rst", {31'h0, core_resetn}, 32'd0);
    send({8'($urandom), 24'(b)});
    for (int w = 0; w < words && !(err && n == 0); w++) begin
      send(load_data[w]);
      if (!err) begin
        for (int j = 0; j < ((n - 4 * w) > 4 ? 4 : (n - 4 * w)); j++) begin
          @(negedge clk);
          chk("wr_en_on", {31'h0, instr_config_wr_en}, 32'd1);
        end
        @(negedge clk);
        chk("wr_en_off", {31'h0, instr_config_wr_en}, 32'd0);
        if (w < words - 1) chk("ready_t5", {31'h0, ready_upward}, 32'd1);
      end
    end
    get_status("load_status", err ? 32'hEE010001 : {8'h01, sum});
    chk("wr_count", wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) chk("wr_data", wq[i], exp_q[i]);
  endtask

  task automatic fill_random(input int n);
    load_data.delete();
    for (int i = 0; i < (n + 3) / 4; i++) load_data.push_back($urandom);
  endtask

  initial begin
    logic [31:0] held;
    int saved;
    resetn = 1'b0; ap_start = 1'b0; din = 32'h0; val_in = 1'b0; ready_downward = 1'b0;
    run_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, ready_upward}, 32'd0);
    chk("rst_val", {31'h0, val_out}, 32'd0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_addr", {8'h0, instr_config_addr}, 32'h0);
    chk("rst_wr", {23'h0, instr_config_wr_en, instr_config_din}, 32'h0);
    chk("rst_core", {30'h0, core_resetn, busy}, 32'h0);
    resetn = 1'b1;
    #1 chk("ready_pre", {31'h0, ready_upward}, 32'd0);
    @(posedge clk);
    #1 chk("ready_rise", {31'h0, ready_upward}, 32'd1);

    // Directed LOAD N=6 at 0x100
    load_data.delete();
    load_data.push_back(32'h44332211);
    load_data.push_back(32'h00006655);
    run_load(6, 32'h100);
    chk("t1_status", {8'h01, 24'h000165}, {8'h01, 24'h11 + 24'h22 + 24'h33 + 24'h44 + 24'h55 + 24'h66});
    if (wq.size() == 6) begin
      chk("t1_first", wq[0], 32'h00010011);
      chk("t1_last", wq[5], 32'h00010566);
    end else begin
      chk("t1_count", wq.size(), 32'd6);
    end

    // START / ap_start toggles / HALT
    ap_start = 1'b1;
    @(negedge clk);
    chk("start_pre", {31'h0, core_resetn}, 32'd0);
    send(32'h02000000);
    chk("start_core", {31'h0, core_resetn}, 32'd1);
    chk("start_val", {31'h0, val_out}, 32'd1);
    get_status("start_status", 32'h02000000);
    @(negedge clk) ap_start = 1'b0;
    @(posedge clk);
    #1 chk("apstart_low", {31'h0, core_resetn}, 32'd0);
    @(negedge clk) ap_start = 1'b1;
    @(posedge clk);
    #1 chk("apstart_high", {31'h0, core_resetn}, 32'd1);
    send(32'h03000000);
    chk("halt_core", {31'h0, core_resetn}, 32'd0);
    get_status("halt_status", 32'h03000000);

    // Range error with drain
    fill_random(8);
    run_load(8, MEM - 4);

    // Unknown command held under backpressure
    send(32'h7F123456);
    @(negedge clk);
    held = 32'hEE02007F;
    for (int i = 0; i < 20; i++) begin
      chk("hold_dout", dout, held);
      chk("hold_vr", {30'h0, val_out, ready_upward}, 32'd2);
      @(negedge clk);
    end
    get_status("unk_status", held);

    // Running core, then empty LOAD
    send(32'h02000000);
    get_status("start2", 32'h02000000);
    chk("run_core", {31'h0, core_resetn}, 32'd1);
    load_data.delete();
    run_load(0, 32'h10);
    repeat (5) @(negedge clk);
    chk("n0_core_hold", {31'h0, core_resetn}, 32'd0);

    // Reset during third byte of a word
    load_data.delete();
    load_data.push_back(32'hDDCCBBAA);
    wq.delete();
    send(32'h01000004);
    send(32'h00000020);
    send(load_data[0]);
    @(posedge clk);
    @(posedge clk);
    #1 chk("mid_third", {23'h0, instr_config_wr_en, instr_config_din}, {23'h0, 1'b1, 8'hCC});
    resetn = 1'b0;
    #1 chk("mid_wr", {31'h0, instr_config_wr_en}, 32'd0);
    chk("mid_outs", {dout[31:1], ready_upward, val_out, core_resetn, busy}, 32'h0);
    chk("mid_addr", {instr_config_addr, instr_config_din}, 32'h0);
    saved = wq.size();
    repeat (3) @(negedge clk);
    chk("mid_nowr", wq.size(), saved);
    chk("mid_noval", {31'h0, val_out}, 32'd0);
    resetn = 1'b1;
    run_m = 1'b0;
    fill_random(7);
    run_load(7, 32'h200);

    // Randomized command stream against the model
    for (int it = 0; it < 40; it++) begin
      int kind;
      int n;
      int b;
      logic [7:0] c;
      kind = $urandom_range(0, 5);
      if (kind <= 1) begin
        n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 13);
        b = ($urandom_range(0, 1) == 1) ? $urandom_range(0, MEM - 1) : $urandom_range(MEM - 16, MEM - 1);
        fill_random(n);
        run_load(n, b);
      end else if (kind == 2) begin
        send(32'h02000000 | {8'h0, 24'($urandom)});
        run_m = 1'b1;
        get_status("r_start", 32'h02000000);
      end else if (kind == 3) begin
        send(32'h03000000);
        run_m = 1'b0;
        get_status("r_halt", 32'h03000000);
      end else if (kind == 4) begin
        c = 8'($urandom_range(4, 255));
        send({c, 24'($urandom)});
        get_status("r_unk", {8'hEE, 8'h02, 8'h00, c});
      end else begin
        @(negedge clk) ap_start = ~ap_start;
        @(posedge clk);
      end
      #1 chk("r_core", {31'h0, core_resetn}, {31'h0, run_m & ap_start});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_boot_ctrl.md
# riscv_boot_ctrl

Boot and run controller for the per-leaf picorv32 core. It consumes a 32-bit command stream from one leaf_interface input port and unpacks LOAD payloads into byte writes on the wrapper's instruction-configuration port. It gates the core's reset under START/HALT commands and returns one 32-bit status word per command on a leaf_interface output port. It sits between leaf_interface and picorv32_wrapper, replacing the direct riscv_addr/riscv_dout/instr_wr_en_out path.

## Interface
- MEM_SIZE, 131072: instruction memory size in bytes; the LOAD range check uses it.
- clk  in  1  user clock (clk_user domain).
- resetn  in  1  asynchronous, active-low reset.
- ap_start  in  1  global enable; core_resetn is forced low while it is 0.
- din  in  32  command/data word from leaf_interface.
- val_in  in  1  din valid.
- ready_upward  out  1  accept; a word transfers when val_in & ready_upward.
- dout  out  32  status word to leaf_interface.
- val_out  out  1  status valid.
- ready_downward  in  1  status accepted when val_out & ready_downward.
- instr_config_addr  out  24  byte address.
- instr_config_din  out  8  byte data.
- instr_config_wr_en  out  1  byte write strobe, one byte per cycle.
- core_resetn  out  1  active-low reset to picorv32_wrapper.
- busy  out  1  high in every state except IDLE.

## Operation
- Header word: cmd = din[31:24], arg = din[23:0].
- Commands:
  - 0x01 LOAD: arg is the byte count N. The next word is the base address B in bits [23:0]; bits [31:24] are ignored. This is followed by ceil(N/4) data words.
  - 0x02 START: set run flag.
  - 0x03 HALT: clear run flag.
  - Any other cmd is an error.
- core_resetn = run_q & ap_start, registered. A LOAD header clears run_q in the cycle it is accepted, so the core is held in reset during the load. run_q is kept across ap_start toggles.
- States:
  - IDLE: ready_upward=1. LOAD goes to LOAD_BASE. START, HALT and unknown commands go to STATUS.
  - LOAD_BASE: ready_upward=1. Latch B. If B+N > MEM_SIZE (25-bit compare), set err and go to DRAIN. Otherwise, if N==0 go to STATUS; else go to LOAD_WAIT.
  - LOAD_WAIT: ready_upward=1. Latch the word and go to LOAD_WR.
  - LOAD_WR: ready_upward=0. Write bytes little-endian: din[7:0] first at the current address. Write 4 bytes, or the remaining count if fewer (last word writes N mod 4 bytes, or 4 if N mod 4 is 0). The address increments by 1 per byte. Then go to LOAD_WAIT if bytes remain, else STATUS.
  - DRAIN: ready_upward=1. Accept and discard ceil(N/4) words, then go to STATUS. If N==0, go straight to STATUS.
  - STATUS: ready_upward=0, val_out=1, dout held stable until ready_downward, then go to IDLE.
- Checksum: 24-bit wrap-around sum of all written bytes, cleared on LOAD header.
- Status word:
  - LOAD ok: {0x01, checksum}.
  - START: {0x02, 24'h0}.
  - HALT: {0x03, 24'h0}.
  - Range error: {0xEE, 8'h01, 8'h00, 8'h01}.
  - Unknown cmd: {0xEE, 8'h02, 8'h00, cmd}.
- Remaining-byte counter is 25 bits wide, so N up to 2^24-1 is handled.

## Timing
- Reset values (async, on resetn=0):
  - ready_upward=0, val_out=0, dout=0.
  - instr_config_addr=0, instr_config_din=0, instr_config_wr_en=0.
  - core_resetn=0, busy=0, run_q=0, state=IDLE.
- ready_upward rises the first cycle after resetn deasserts.
- All outputs are registered.
- Data word accepted at cycle t: byte writes appear at t+1 through t+4, with wr_en high for exactly those cycles. ready_upward returns high at t+5, giving 5 cycles per full word.
- START accepted at t: core_resetn=1 at t+1 if ap_start=1, and val_out=1 at t+1.
- LOAD header accepted at t: core_resetn=0 at t+1.
- The first write is never earlier than the cycle after the base word is accepted.
- val_out stays asserted with dout constant under ready_downward=0 for any duration. No input word is accepted while val_out=1.
- ap_start falls: core_resetn=0 the next cycle. It returns to run_q the cycle after ap_start rises.
- resetn asserted mid-load: the load is abandoned immediately. No further writes occur and no status word is sent.

## Test plan
- LOAD N=6, B=0x000100, data 0x44332211, 0x00006655: writes 0x11..0x66 at 0x100..0x105, 6 wr_en pulses total. Status {0x01, 0x000165}.
- START with ap_start=1: core_resetn 0→1 one cycle after accept; status 0x02000000. Drop ap_start: core_resetn=0 next cycle. Raise ap_start: core_resetn=1. HALT: core_resetn=0; status 0x03000000.
- LOAD N=8, B=MEM_SIZE-4: two data words drained, zero writes; status 0xEE010001.
- Unknown cmd 0x7F: status 0xEE02007F. Hold ready_downward=0 for 20 cycles: dout/val_out stable, ready_upward=0 throughout.
- Running core, then LOAD N=0: core_resetn drops, no writes, status 0x01000000, core stays in reset until the next START.
- Assert resetn=0 during the third byte write of a word: wr_en=0 and all outputs at reset values immediately. After release, a fresh LOAD completes normally.
